bin_to_display_digits: RTL and testbench
========================================

Name: bin_to_display_digits

Overview:
- Upstream feeder for the 3-digit multiplexed seven-segment driver.
- Converts a binary value into three 4-bit digit codes, SEG0 (least significant) to SEG2, plus three decimal-point flags LED[2:0], held stable for the driver.
- Decimal mode uses a sequential shift-and-add-3 (double-dabble) conversion; hex mode passes the nibbles straight through.
- Start/busy/done handshake so a CPU-side register or debug port can post new values.

Parameters:
- IN_W, 12: width of the binary input; legal range 4..12. The decimal conversion runs IN_W iterations.
- DEC_MAX, 999: largest value shown in decimal mode. Values above it saturate.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; accepted only when busy=0.
- hex_mode  in  1  sampled with start: 1 = hex display, 0 = decimal display.
- value  in  IN_W  binary value, sampled with start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  single-cycle pulse when SEG0..SEG2 and LED update.
- SEG0  out  4  ones digit (decimal) or value[3:0] (hex).
- SEG1  out  4  tens digit or value[7:4].
- SEG2  out  4  hundreds digit or value[11:8], zero-extended.
- LED  out  3  decimal-point flags: bit0 = hex indicator, bit2 = decimal overflow, bit1 always 0.

Behaviour:
- Reset (synchronous, Reset=1 at an edge): state IDLE; SEG0/1/2=0, LED=0, busy=0, done=0; iteration counter and scratch cleared.
  - Reset dominates start.
  - Reset mid-conversion abandons it; no done pulse.
- Accept: at an edge where state=IDLE and start=1.
  - Latch value (zero-extended to 12 bits), hex_mode, and ovf = (value > DEC_MAX).
  - start while busy=1 is ignored; it is not queued.
- States: IDLE, CONV, LOAD.
  - IDLE -> LOAD on an accept with hex_mode=1.
  - IDLE -> CONV on an accept with hex_mode=0, and iteration count := 0.
  - CONV -> CONV while count < IN_W-1.
  - CONV -> LOAD when count = IN_W-1.
  - LOAD -> IDLE, always.
- CONV, each cycle:
  - Every BCD digit of the 16-bit scratch (4 digits) that is >= 5 gets +3.
  - Then {scratch, shift_reg} shifts left by 1, with the MSB of value entering first.
  - Exactly one iteration per cycle.
- LOAD edge: outputs register; done=1 for exactly this one cycle; busy goes 0 on the same edge.
  - Hex: SEG0..SEG2 = the three nibbles; LED = 3'b001.
  - Decimal, ovf=0: SEG0..SEG2 = BCD ones/tens/hundreds; LED = 3'b000.
  - Decimal, ovf=1: SEG0..SEG2 = 9,9,9; LED = 3'b100.
- busy=1 in CONV and LOAD, 0 in IDLE.
- Latency, start accepted at edge N:
  - Hex: outputs change and done is high after edge N+1.
  - Decimal: outputs change and done is high after edge N+IN_W+1 (13 for the default).
- Back-to-back: start held high re-accepts at the edge following the return to IDLE (one idle cycle between conversions).
- Outputs hold their last values between conversions; no glitching during CONV (scratch is internal only).
- Digit codes are always 0..9 in decimal mode and 0..F in hex mode, so every code the downstream decoder sees is legal.

Decomposition:
- Shared package display_pkg:
  - state enum {IDLE, CONV, LOAD};
  - localparams DEC_MAX_DEFAULT=999, BCD_DIGITS=4;
  - LED flag bit positions LED_HEX=0, LED_OVF=2;
  - 4-bit digit typedef.
- One natural sub-module: bcd_adj3, a combinational 4-bit correction (in >= 5 ? in+3 : in), instantiated once per scratch digit.

Test Plan:
- Reset, then idle 5 cycles -> SEG0..SEG2=0, LED=0, busy=0, done never pulses.
- hex_mode=0, value=12'd473, start 1 cycle -> busy high 13 cycles; done pulses once, 13 cycles after accept; SEG2=4, SEG1=7, SEG0=3, LED=000.
- hex_mode=0, value=12'd1000, then separately 12'd4095 -> SEG=9,9,9, LED=100 both times; value=12'd999 -> 9,9,9 with LED=000.
- hex_mode=1, value=12'hA5C -> done pulses 1 cycle after accept; SEG2=A, SEG1=5, SEG0=C, LED=001.
- Decimal 12'd205 started, second start (12'd7) pulsed mid-CONV -> ignored; result 2,0,5.
  - Start 12'd7 after done -> result 0,0,7.
- Decimal 12'd888 started; Reset asserted at iteration 6 -> next cycle outputs 0, busy=0, no done.
  - New start 12'd1 -> result 0,0,1 after 13 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-display-digit converter.
//   state_e  : converter sequencing states
//   digit_t  : one 4-bit display digit code
//   LED_*    : bit positions of the decimal-point flags
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  typedef logic [3:0] digit_t;

  localparam int DEC_MAX_DEFAULT = 999;
  localparam int BCD_DIGITS      = 4;
  localparam int VAL_W           = 12;  // widest value the display can carry

  localparam int LED_HEX = 0;
  localparam int LED_OVF = 2;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so that the following left shift carries correctly into the next digit.
//   digit_i : scratch BCD digit before the shift
//   digit_o : corrected digit
module bcd_adj3
  import display_pkg::*;
(
  input  digit_t digit_i,
  output digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_display_digits.sv
// Converts a binary value into three display digit codes plus three
// decimal-point flags for the multiplexed seven-segment driver.
// Decimal mode runs a sequential double-dabble, one bit per clock;
// hex mode passes the nibbles straight through.
//   Clk, Reset        : clock, synchronous active-high reset
//   start, hex_mode,  : conversion request; mode and value are sampled
//   value               when the request is accepted in IDLE
//   busy, done        : busy while converting, done pulses as outputs update
//   SEG0..SEG2        : digit codes, least significant first
//   LED               : bit0 hex indicator, bit2 decimal overflow
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// CONV  | one double-dabble iteration per cycle
// LOAD  | register digits/flags, pulse done
module bin_to_display_digits
  import display_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int DEC_MAX = DEC_MAX_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic            hex_mode,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [3:0]      SEG0,
  output logic [3:0]      SEG1,
  output logic [3:0]      SEG2,
  output logic [2:0]      LED
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);
  localparam logic [31:0]      DEC_MAX_U = 32'(DEC_MAX);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [4*BCD_DIGITS-1:0] scratch_q;
  logic [IN_W-1:0]         shift_q;
  logic                    hex_q;
  logic                    ovf_q;
  digit_t                  seg0_q, seg1_q, seg2_q;
  logic [2:0]              led_q;
  logic                    busy_q;
  logic                    done_q;

  digit_t                  seg0_d, seg1_d, seg2_d;
  logic [2:0]              led_d;
  logic [4*BCD_DIGITS-1:0] scratch_adj;
  logic [4*BCD_DIGITS-1:0] scratch_shift;
  logic [VAL_W-1:0]        val_ext;
  logic                    ovf_in;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .digit_i(scratch_q[4*g +: 4]),
      .digit_o(scratch_adj[4*g +: 4])
    );
  end

  // Correct every digit, then shift the next value MSB into the scratch LSB.
  assign scratch_shift = {scratch_adj[4*BCD_DIGITS-2:0], shift_q[IN_W-1]};

  assign ovf_in  = 32'(value) > DEC_MAX_U;
  // In hex mode shift_q never moves, so it still holds the accepted value.
  assign val_ext = VAL_W'(shift_q);

  // The thousands digit only matters for the carry chain, never displayed.
  logic unused_bits;
  assign unused_bits = ^{scratch_adj[4*BCD_DIGITS-1], scratch_q[4*BCD_DIGITS-1:12]};

  always_comb begin
    seg0_d = '0;
    seg1_d = '0;
    seg2_d = '0;
    led_d  = '0;
    if (hex_q) begin
      seg0_d         = val_ext[3:0];
      seg1_d         = val_ext[7:4];
      seg2_d         = val_ext[11:8];
      led_d[LED_HEX] = 1'b1;
    end else if (ovf_q) begin
      seg0_d         = 4'd9;
      seg1_d         = 4'd9;
      seg2_d         = 4'd9;
      led_d[LED_OVF] = 1'b1;
    end else begin
      seg0_d = scratch_q[3:0];
      seg1_d = scratch_q[7:4];
      seg2_d = scratch_q[11:8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      scratch_q <= '0;
      shift_q   <= '0;
      hex_q     <= 1'b0;
      ovf_q     <= 1'b0;
      seg0_q    <= '0;
      seg1_q    <= '0;
      seg2_q    <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= value;
            hex_q     <= hex_mode;
            ovf_q     <= ovf_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= hex_mode ? LOAD : CONV;
          end
        end
        CONV: begin
          scratch_q <= scratch_shift;
          shift_q   <= shift_q << 1;
          if (cnt_q == LAST_ITER) begin
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOAD: begin
          seg0_q  <= seg0_d;
          seg1_q  <= seg1_d;
          seg2_q  <= seg2_d;
          led_q   <= led_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign SEG0 = seg0_q;
  assign SEG1 = seg1_q;
  assign SEG2 = seg2_q;
  assign LED  = led_q;

endmodule

// File: tb/tb_bin_to_display_digits.sv
module tb_bin_to_display_digits;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        hex_mode;
  logic [11:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  SEG0, SEG1, SEG2;
  logic [2:0]  LED;

  always #5 Clk = ~Clk;

  bin_to_display_digits #(.IN_W(12), .DEC_MAX(999)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .hex_mode(hex_mode),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .SEG0    (SEG0),
    .SEG1    (SEG1),
    .SEG2    (SEG2),
    .LED     (LED)
  );

  typedef struct {
    logic [3:0] s2, s1, s0;
    logic [2:0] led;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t exp_of(input logic h, input logic [11:0] v);
    exp_t e;
    int   iv;
    iv    = int'(v);
    e.cyc = 0;
    if (h) begin
      e.s2 = v[11:8]; e.s1 = v[7:4]; e.s0 = v[3:0]; e.led = 3'b001;
    end else if (iv > 999) begin
      e.s2 = 4'd9; e.s1 = 4'd9; e.s0 = 4'd9; e.led = 3'b100;
    end else begin
      e.s2 = 4'(iv / 100); e.s1 = 4'((iv / 10) % 10); e.s0 = 4'(iv % 10); e.led = 3'b000;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("seg2", 32'(SEG2), 32'(e.s2));
        check("seg1", 32'(SEG1), 32'(e.s1));
        check("seg0", 32'(SEG0), 32'(e.s0));
        check("led", 32'(LED), 32'(e.led));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic do_start(input logic h, input logic [11:0] v);
    exp_t e;
    @(negedge Clk);
    start = 1'b1; hex_mode = h; value = v;
    @(posedge Clk); #1;
    e     = exp_of(h, v);
    e.cyc = cyc + (h ? 1 : 13);
    sb.push_back(e);
    @(negedge Clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else begin
      check("busy_low_at_done", 32'(busy), 32'd0);
      @(negedge Clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  int bc;

  initial begin
    Reset = 1'b1; start = 1'b0; hex_mode = 1'b0; value = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("idle_outs", 32'({SEG2, SEG1, SEG0, LED}), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    do_start(1'b0, 12'd473);
    wait_done(bc);
    check("busy_cycles_dec", 32'(bc + 1), 32'd13);

    do_start(1'b0, 12'd1000); wait_done(bc);
    do_start(1'b0, 12'd4095); wait_done(bc);
    do_start(1'b0, 12'd999);  wait_done(bc);

    do_start(1'b1, 12'hA5C);
    wait_done(bc);
    check("busy_cycles_hex", 32'(bc + 1), 32'd1);

    // Start held high: re-accept one idle cycle after returning to IDLE.
    begin
      exp_t e;
      int   n;
      @(negedge Clk);
      start = 1'b1; hex_mode = 1'b1; value = 12'h3F0;
      @(posedge Clk); #1;
      n = cyc;
      e = exp_of(1'b1, 12'h3F0);
      e.cyc = n + 1; sb.push_back(e);
      e.cyc = n + 3; sb.push_back(e);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      start = 1'b0;
      repeat (4) @(negedge Clk);
      check("b2b_drained", 32'(sb.size()), 32'd0);
    end

    // Second start during CONV is ignored.
    do_start(1'b0, 12'd205);
    repeat (3) @(negedge Clk);
    start = 1'b1; value = 12'd7; hex_mode = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    wait_done(bc);
    repeat (3) @(negedge Clk);
    check("ignored_start", 32'(sb.size()), 32'd0);

    do_start(1'b0, 12'd7); wait_done(bc);

    // Reset mid-conversion abandons it.
    do_start(1'b0, 12'd888);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    void'(sb.pop_back());
    @(negedge Clk);
    check("rst_outs", 32'({SEG2, SEG1, SEG0, LED}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);

    do_start(1'b0, 12'd1); wait_done(bc);
    do_start(1'b0, 12'd0); wait_done(bc);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
